// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line serial engine.
// Frame lengths count every bit on the wire, start and end bits included.
package sd_cmd_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_TX,
      ST_WAIT_RESP,
      ST_RX
   } state_t;

   localparam int SET_RESP_BIT       = 0;
   localparam int SET_LONG_BIT       = 1;
   localparam int SHORT_LEN          = 48;
   localparam int LONG_LEN           = 136;
   localparam int INIT_DELAY_DEF     = 64;
   localparam int RESP_TIMEOUT_DEF   = 64;
   localparam logic [6:0] CRC7_POLY  = 7'h09;

   // One serial step of CRC7 (x^7 + x^3 + 1).
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clr has priority over en and zeroes the register.
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         crc <= 7'h00;
      end else if (en) begin
         crc <= crc7_step(crc, din);
      end
   end

endmodule

// File: rtl/sd_cmd_serial_host_core.sv
// SD CMD-line serial engine: power-up idle-high, 48-bit command transmit,
// and optional short/long response capture with CRC7 and index checking.
module sd_cmd_serial_host_core
   import sd_cmd_pkg::*;
#(
   parameter int INIT_DELAY   = INIT_DELAY_DEF,
   parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
   input  logic         sd_clk,
   input  logic         rst,
   input  logic [1:0]   setting_i,
   input  logic [39:0]  cmd_i,
   input  logic         start_i,
   input  logic         cmd_dat_i,
   output logic         cmd_out_o,
   output logic         cmd_oe_o,
   output logic [119:0] response_o,
   output logic         finish_o,
   output logic         crc_ok_o,
   output logic         index_ok_o,
   output state_t       dbg_state_o
);

   state_t        state;
   logic [15:0]   wait_cnt;
   logic [7:0]    bit_cnt;
   logic [38:0]   tx_shift;
   logic [5:0]    cmd_index;
   logic          resp_expect;
   logic          resp_long;
   logic [126:0]  rx_shift;
   logic [6:0]    tx_crc;
   logic [6:0]    rx_crc;
   logic          tx_crc_clr, tx_crc_en, tx_crc_din;
   logic          rx_crc_clr, rx_crc_en;
   logic [7:0]    rx_last;
   logic [2:0]    crc_sel;

   assign dbg_state_o = state;
   assign rx_last     = resp_long ? 8'(LONG_LEN - 1) : 8'(SHORT_LEN - 1);
   // bit_cnt is the index of the bit on the line; 39..45 launch CRC bits 6..0.
   assign crc_sel     = 3'(8'd45 - bit_cnt);

   // TX CRC is fed with each command bit at the edge that launches it, so the
   // full CRC is ready exactly when the first CRC bit must go out.
   always_comb begin
      tx_crc_clr = 1'b1;
      tx_crc_en  = 1'b0;
      tx_crc_din = tx_shift[38];
      if (state == ST_IDLE && start_i) begin
         tx_crc_clr = 1'b0;
         tx_crc_en  = 1'b1;
         tx_crc_din = cmd_i[39];
      end else if (state == ST_TX) begin
         tx_crc_clr = (bit_cnt == 8'(SHORT_LEN - 1));
         tx_crc_en  = (bit_cnt < 8'd39);
      end
   end

   // Short responses include the start bit in the CRC; long ones cover payload only.
   always_comb begin
      rx_crc_clr = 1'b1;
      rx_crc_en  = 1'b0;
      if (state == ST_WAIT_RESP) begin
         rx_crc_clr = 1'b0;
         rx_crc_en  = !cmd_dat_i && !resp_long;
      end else if (state == ST_RX) begin
         rx_crc_clr = 1'b0;
         rx_crc_en  = resp_long ? (bit_cnt >= 8'd8 && bit_cnt < 8'd128)
                                : (bit_cnt < 8'd40);
      end
   end

   sd_crc7 u_tx_crc (
      .clk (sd_clk),
      .rst (rst),
      .clr (tx_crc_clr),
      .en  (tx_crc_en),
      .din (tx_crc_din),
      .crc (tx_crc)
   );

   sd_crc7 u_rx_crc (
      .clk (sd_clk),
      .rst (rst),
      .clr (rx_crc_clr),
      .en  (rx_crc_en),
      .din (cmd_dat_i),
      .crc (rx_crc)
   );

   always_ff @(posedge sd_clk) begin
      if (rst) begin
         state       <= ST_INIT;
         wait_cnt    <= 16'd0;
         bit_cnt     <= 8'd0;
         tx_shift    <= 39'd0;
         cmd_index   <= 6'd0;
         resp_expect <= 1'b0;
         resp_long   <= 1'b0;
         rx_shift    <= 127'd0;
         cmd_oe_o    <= 1'b1;
         cmd_out_o   <= 1'b1;
         response_o  <= 120'd0;
         finish_o    <= 1'b0;
         crc_ok_o    <= 1'b0;
         index_ok_o  <= 1'b0;
      end else begin
         finish_o <= 1'b0;
         case (state)
            ST_INIT: begin
               cmd_oe_o  <= 1'b1;
               cmd_out_o <= 1'b1;
               if (wait_cnt == 16'(INIT_DELAY - 1)) begin
                  state    <= ST_IDLE;
                  cmd_oe_o <= 1'b0;
                  wait_cnt <= 16'd0;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            ST_IDLE: begin
               cmd_oe_o  <= 1'b0;
               cmd_out_o <= 1'b1;
               if (start_i) begin
                  tx_shift    <= cmd_i[38:0];
                  cmd_index   <= cmd_i[37:32];
                  resp_expect <= setting_i[SET_RESP_BIT];
                  resp_long   <= setting_i[SET_RESP_BIT] & setting_i[SET_LONG_BIT];
                  response_o  <= 120'd0;
                  crc_ok_o    <= 1'b0;
                  index_ok_o  <= 1'b0;
                  cmd_oe_o    <= 1'b1;
                  cmd_out_o   <= cmd_i[39];
                  bit_cnt     <= 8'd0;
                  state       <= ST_TX;
               end
            end
            ST_TX: begin
               bit_cnt <= bit_cnt + 8'd1;
               if (bit_cnt < 8'd39) begin
                  cmd_out_o <= tx_shift[38];
                  tx_shift  <= {tx_shift[37:0], 1'b0};
               end else if (bit_cnt < 8'd46) begin
                  cmd_out_o <= tx_crc[crc_sel];
               end else if (bit_cnt == 8'd46) begin
                  cmd_out_o <= 1'b1;
               end else begin
                  cmd_oe_o  <= 1'b0;
                  cmd_out_o <= 1'b1;
                  bit_cnt   <= 8'd0;
                  wait_cnt  <= 16'd0;
                  if (resp_expect) begin
                     state <= ST_WAIT_RESP;
                  end else begin
                     finish_o <= 1'b1;
                     state    <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_RESP: begin
               cmd_oe_o <= 1'b0;
               if (!cmd_dat_i) begin
                  state    <= ST_RX;
                  bit_cnt  <= 8'd1;
                  rx_shift <= {rx_shift[125:0], cmd_dat_i};
               end else if (wait_cnt == 16'(RESP_TIMEOUT - 1)) begin
                  finish_o   <= 1'b1;
                  crc_ok_o   <= 1'b0;
                  index_ok_o <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            ST_RX: begin
               rx_shift <= {rx_shift[125:0], cmd_dat_i};
               // At the end bit, rx_shift[0] is the CRC LSB and the end bit is not kept.
               if (bit_cnt == rx_last) begin
                  finish_o <= 1'b1;
                  crc_ok_o <= (rx_shift[6:0] == rx_crc);
                  state    <= ST_IDLE;
                  if (resp_long) begin
                     response_o <= rx_shift[126:7];
                     index_ok_o <= 1'b1;
                  end else begin
                     response_o <= {rx_shift[38:7], 88'd0};
                     index_ok_o <= (rx_shift[44:39] == cmd_index);
                  end
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_serial_host_core.sv
// Directed bench for the SD CMD-line engine: a card model answers on the
// line, and expected bits/results are queued and compared as the DUT emits them.
module tb_sd_cmd_serial_host_core;

   localparam int INIT_DELAY   = 64;
   localparam int RESP_TIMEOUT = 64;

   logic                  sd_clk;
   logic                  rst;
   logic [1:0]            setting_i;
   logic [39:0]           cmd_i;
   logic                  start_i;
   logic                  cmd_dat_i;
   logic                  cmd_out_o;
   logic                  cmd_oe_o;
   logic [119:0]          response_o;
   logic                  finish_o;
   logic                  crc_ok_o;
   logic                  index_ok_o;
   sd_cmd_pkg::state_t    dbg_state;

   logic [0:0]   bit_q[$];
   logic [121:0] exp_q[$];
   int           pass_cnt = 0;
   int           total_cnt = 0;

   sd_cmd_serial_host_core #(
      .INIT_DELAY   (INIT_DELAY),
      .RESP_TIMEOUT (RESP_TIMEOUT)
   ) dut (
      .sd_clk      (sd_clk),
      .rst         (rst),
      .setting_i   (setting_i),
      .cmd_i       (cmd_i),
      .start_i     (start_i),
      .cmd_dat_i   (cmd_dat_i),
      .cmd_out_o   (cmd_out_o),
      .cmd_oe_o    (cmd_oe_o),
      .response_o  (response_o),
      .finish_o    (finish_o),
      .crc_ok_o    (crc_ok_o),
      .index_ok_o  (index_ok_o),
      .dbg_state_o (dbg_state)
   );

   // Clock / reset
   initial begin
      sd_clk = 1'b0;
      forever #5 sd_clk = ~sd_clk;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference CRC7 over d[n-1:0], MSB first, register starting at zero.
   function automatic logic [6:0] crc7_bits(input logic [135:0] d, input int n);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = n - 1; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return c;
   endfunction

   // Driver: issue one command, check the serial stream, play the card reply
   // (frame_len = 0 leaves the line high), then check the completion result.
   task automatic run_cmd(input string name, input logic [1:0] setting, input logic [39:0] cmd,
                          input logic [135:0] frame, input int frame_len,
                          input logic [121:0] exp_res, input bit mid_start);
      logic [47:0]  tx_frame;
      logic [0:0]   eb;
      logic [121:0] got;
      int           waited;
      tx_frame = {cmd, crc7_bits({96'd0, cmd}, 40), 1'b1};
      for (int i = 47; i >= 0; i--) bit_q.push_back(tx_frame[i]);
      exp_q.push_back(exp_res);
      cmd_i     = cmd;
      setting_i = setting;
      start_i   = 1'b1;
      @(negedge sd_clk);
      start_i = 1'b0;
      for (int i = 0; i < 48; i++) begin
         if (i > 0) @(negedge sd_clk);
         if (mid_start && i == 10) begin
            start_i   = 1'b1;
            cmd_i     = ~cmd;
            setting_i = 2'b01;
         end else begin
            start_i = 1'b0;
         end
         eb = bit_q.pop_front();
         check({name, "_tx_oe"}, cmd_oe_o, 1'b1);
         check({name, "_tx_bit"}, cmd_out_o, eb);
         check({name, "_tx_fin"}, finish_o, 1'b0);
      end
      start_i = 1'b0;
      @(negedge sd_clk);
      check({name, "_oe_drop"}, cmd_oe_o, 1'b0);
      if (!setting[0]) begin
         check({name, "_fin_nresp"}, finish_o, 1'b1);
      end else begin
         check({name, "_fin_low_at_drop"}, finish_o, 1'b0);
         for (int i = frame_len - 1; i >= 0; i--) begin
            cmd_dat_i = frame[i];
            @(negedge sd_clk);
         end
         cmd_dat_i = 1'b1;
         waited = 0;
         while (finish_o !== 1'b1 && waited < 200) begin
            @(negedge sd_clk);
            waited++;
         end
         check({name, "_fin_resp"}, finish_o, 1'b1);
         if (frame_len == 0)
            check({name, "_timeout_win"},
                  (waited >= RESP_TIMEOUT - 1 && waited <= RESP_TIMEOUT + 1), 1'b1);
         else
            check({name, "_resp_latency"}, waited, 0);
      end
      got = {crc_ok_o, index_ok_o, response_o};
      check({name, "_result"}, got, exp_q.pop_front());
      @(negedge sd_clk);
      check({name, "_fin_pulse"}, finish_o, 1'b0);
      check({name, "_hold"}, {crc_ok_o, index_ok_o, response_o}, exp_res);
      repeat (2) @(negedge sd_clk);
   endtask

   logic [127:0] r_word;
   logic [39:0]  cmd_word;
   logic [39:0]  short_hdr;
   logic [39:0]  bad_hdr;
   logic [135:0] short_frame;
   logic [135:0] long_frame;
   logic [135:0] bad_frame;
   int           cyc;

   initial begin
      rst       = 1'b1;
      start_i   = 1'b0;
      setting_i = 2'b00;
      cmd_i     = 40'd0;
      cmd_dat_i = 1'b1;

      cmd_word    = 40'h0123456786;
      r_word      = 128'h0156789abcdef0123456789abcdef012;
      short_hdr   = r_word[127:88];
      short_frame = {88'd0, short_hdr, crc7_bits({96'd0, short_hdr}, 40), 1'b1};
      long_frame  = {r_word, crc7_bits({16'd0, r_word[119:0]}, 120), 1'b1};
      bad_hdr     = {short_hdr[39:38], 6'd2, short_hdr[31:0]};
      bad_frame   = {88'd0, bad_hdr, crc7_bits({96'd0, bad_hdr}, 40) ^ 7'h04, 1'b1};

      repeat (3) @(negedge sd_clk);
      check("rst_oe", cmd_oe_o, 1'b1);
      check("rst_out", cmd_out_o, 1'b1);
      check("rst_fin", finish_o, 1'b0);
      check("rst_crc_ok", crc_ok_o, 1'b0);
      check("rst_idx_ok", index_ok_o, 1'b0);
      check("rst_resp", response_o, 120'd0);

      // Release reset with a start pulse that INIT must ignore.
      rst     = 1'b0;
      start_i = 1'b1;
      cmd_i   = cmd_word;
      cyc     = 0;
      while (cmd_oe_o === 1'b1 && cyc < 100) begin
         @(negedge sd_clk);
         start_i = 1'b0;
         cyc++;
         if (cmd_oe_o === 1'b1) begin
            check("init_out", cmd_out_o, 1'b1);
            check("init_fin", finish_o, 1'b0);
         end
      end
      check("init_len", (cyc >= 60 && cyc <= 66), 1'b1);
      check("init_flags", {crc_ok_o, index_ok_o}, 2'b00);
      repeat (2) @(negedge sd_clk);

      run_cmd("nresp", 2'b00, cmd_word, 136'd0, 0, 122'd0, 1'b0);
      run_cmd("short", 2'b01, cmd_word, short_frame, 48,
              {1'b1, 1'b1, 32'h56789abc, 88'd0}, 1'b0);
      run_cmd("long", 2'b11, cmd_word, long_frame, 136,
              {1'b1, 1'b1, r_word[119:0]}, 1'b0);
      run_cmd("clear", 2'b00, cmd_word, 136'd0, 0, 122'd0, 1'b0);
      run_cmd("bad", 2'b01, cmd_word, bad_frame, 48,
              {1'b0, 1'b0, 32'h56789abc, 88'd0}, 1'b0);
      run_cmd("timeout", 2'b01, cmd_word, 136'd0, 0, 122'd0, 1'b0);
      run_cmd("midstart", 2'b00, cmd_word, 136'd0, 0, 122'd0, 1'b1);

      check("bit_q_empty", bit_q.size(), 0);
      check("exp_q_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sd_cmd_serial_host_core.md
Name: sd_cmd_serial_host_core

Overview:
Serial engine for the SD-card CMD line, sitting between the SD command master and the CMD pad.
- After reset it drives the line high for the card power-up sequence.
- On request it sends a 48-bit command frame: 40 payload bits, CRC7, end bit.
- It can then receive a short (48-bit) or long (136-bit) response, check its CRC and index, and pulse finish.

Parameters:
INIT_DELAY, 64, sd_clk cycles spent in INIT after reset release (line driven high).
RESP_TIMEOUT, 64, cycles in WAIT_RESP without a start bit before the transaction is aborted.

Ports:
sd_clk  in  1  SD clock; all logic on rising edge. One clock only.
rst  in  1  reset, synchronous, active-high.
setting_i  in  2  bit0 = response expected, bit1 = long response (ignored if bit0=0).
cmd_i  in  40  raw command bits 39:0, sent MSB first (start, tx, index[37:32], arg).
start_i  in  1  one-cycle request, sampled in IDLE.
cmd_dat_i  in  1  CMD line input, sampled at rising edge.
cmd_out_o  out  1  CMD line output value.
cmd_oe_o  out  1  CMD line output enable.
response_o  out  120  received response payload.
finish_o  out  1  one-cycle completion pulse.
crc_ok_o  out  1  response CRC matched.
index_ok_o  out  1  response index matched.

Behaviour:
Reset values and reset mid-operation:
- Reset values: cmd_oe_o=1, cmd_out_o=1, finish_o=0, crc_ok_o=0, index_ok_o=0, response_o=0.
- Reset asserted in any state returns to INIT with these values.

States and transitions:
- INIT: oe=1, out=1 for INIT_DELAY cycles after rst deasserts, then IDLE. start_i is ignored.
- IDLE: oe=0.
  - On the edge sampling start_i=1: latch cmd_i and setting_i; clear crc_ok_o, index_ok_o and response_o; enter TX.
  - The same edge drives oe=1 and out=cmd_i[39].
- TX: one bit per cycle for 48 cycles total.
  - Bits 39..0 of the latched command.
  - Then 7 CRC bits, MSB first.
  - Then end bit '1'.
  - On the edge after the end bit: oe=0.
    - No response expected: finish_o=1 on that edge, go to IDLE.
    - Response expected: enter WAIT_RESP; finish_o stays 0.
- WAIT_RESP: oe=0.
  - The first sampled cmd_dat_i=0 (start bit) enters RX; this is possible from the very first edge after oe drops.
  - After RESP_TIMEOUT cycles with no start bit: finish_o pulse, crc_ok_o=0, index_ok_o=0, go to IDLE.
- RX: total frame including start bit is 48 bits (short) or 136 bits (long); sampled bits are shifted into a register.
  - Short frame: start, tx, index[5:0], 32 status bits, CRC7, end.
    - response_o[119:88] = status; response_o[87:0] = 0.
    - CRC covers the first 40 bits, including start.
    - index_ok_o = (received index == latched cmd[37:32]).
  - Long frame: start, tx, 6 reserved bits, 120 payload bits, CRC7, end.
    - response_o[119:0] = payload.
    - CRC covers the 120 payload bits only.
    - index_ok_o = 1.
  - On the edge sampling the end bit: finish_o=1 for one cycle; crc_ok_o = (received CRC == computed CRC); response_o and index_ok_o are updated. Then go to IDLE.
  - The end-bit value is not checked.
- crc_ok_o, index_ok_o and response_o hold their values until the next accepted start_i. For a no-response command they stay 0.
- start_i outside IDLE is ignored.

CRC7 rules:
- Polynomial x^7+x^3+1.
- Register initialised to 0 per frame.
- Per bit: fb = bit ^ crc[6]; crc = {crc[5:0],0} ^ (fb ? 7'h09 : 0).

Decomposition:
- Package sd_cmd_pkg: state enum (INIT, IDLE, TX, WAIT_RESP, RX); setting bit positions; frame lengths 48/136; INIT_DELAY default.
- Sub-module sd_crc7: serial CRC7 with clear/enable/bit inputs and 7-bit output, instantiated once for TX and once for RX.

Test Plan:
- Reset 3 cycles, release -> oe=1, out=1, finish/crc_ok/index_ok=0 through INIT; oe=0 by 66 cycles after release.
- setting=0, cmd=40'h0123456786 -> 48 driven bits: cmd MSB first, CRC7 matching the model, end '1'.
  - oe drops the next edge; finish pulses once; crc_ok=0, index_ok=0.
- setting=1, same cmd; card replies immediately after oe drops with bits 127:88 of 128'h0156789abcdef0123456789abcdef012, then correct CRC and end -> finish pulse, response_o[119:88]=32'h56789abc, crc_ok=1, index_ok=1.
  - finish_o stays 0 when oe drops.
- setting=3, same cmd; card sends all 128 bits above, CRC7 over bits 119:0, end -> response_o = low 120 bits, crc_ok=1, index_ok=1.
- setting=1 with one flipped CRC bit and index 2 -> crc_ok=0, index_ok=0, finish pulse.
- setting=1, line held high -> finish pulse after RESP_TIMEOUT with crc_ok=0, index_ok=0.
  - Then start_i pulsed mid-TX is ignored.
